odd_even_switch_allocator: RTL and testbench
============================================

// Module: odd_even_switch_allocator
// PURPOSE
//  Per-router switch allocator placed after routing_odd_even. For each input holding a head flit it
//  chooses one output from the permitted odd-even directions, arbitrates conflicts round-robin, and
//  locks that output to the input until the tail flit (wormhole). It also tracks downstream credits
//  per output and drives the crossbar select.
// PARAMETERS
//  N      5  ports/outputs, index order [0 local, 1 north, 2 east, 3 south, 4 west]
//  DEPTH  4  downstream input-buffer depth in flits (reset credit count per output)
//  CW     $clog2(DEPTH+1)  credit counter width (derived, not overridable)
// PORTS
//  i_clk            in   1        clock, all state on rising edge
//  i_reset          in   1        asynchronous, active-high reset
//  i_valid          in   N        input i presents a flit this cycle
//  i_head           in   N        flit on input i is a head
//  i_tail           in   N        flit on input i is a tail (head&tail = single-flit packet)
//  i_cand           in   N*N      [i][o]=1: output o permitted for input i's head (from routing)
//  i_credit_return  in   N        output o's downstream buffer freed one slot
//  o_grant          out  N        input i's flit is forwarded this cycle (pop it)
//  o_xbar_valid     out  N        output o carries a flit this cycle
//  o_xbar_sel       out  N*log2N  input index driving output o
//  o_err            out  1        sticky protocol-error flag
// BEHAVIOUR
//  State: per output lock (free | owner input), credit[o] (CW bits), rr_ptr[o] (log2N bits).
//  Reset (async assert, sync use): all outputs free, credit=DEPTH, rr_ptr=0, o_err=0; o_grant,
//  o_xbar_valid, o_xbar_sel all 0 combinationally while i_reset=1.
//  Grants are combinational from state+inputs in the same cycle (zero-cycle latency); state updates
//  at the edge. Combinational path order:
//  1 Head selection: for valid head on input i, eligible = i_cand[i] & free & credit>0. Pick eligible
//    output with largest credit; tie -> lowest index. None eligible -> input i waits.
//  2 Output arbitration: per free output, among inputs that picked it, winner = first at/after
//    rr_ptr[o] (wrapping N-1 -> 0). Losers request again next cycle (choice may differ).
//  3 Body/tail: valid non-head on input i that owns output o is granted iff credit[o]>0; no
//    arbitration (owner exclusive).
//  o_xbar_valid[o]=1 and o_xbar_sel[o]=granted input iff some input granted on o; else sel=0.
//  Edge updates:
//  - Head granted without tail: lock o to i. Granted tail (incl. head&tail): o free next cycle; a
//    new head may win o the cycle after the tail, never in the tail's own cycle.
//  - rr_ptr[o] <= (winner+1) mod N only on a head grant on o; unchanged otherwise.
//  - credit[o]: -1 per forwarded flit, +1 per i_credit_return; both in one cycle -> unchanged.
//  Errors (set o_err, cleared only by reset):
//  - i_credit_return while credit=DEPTH and no flit forwarded on o: credit holds at DEPTH.
//  - valid non-head flit on input owning no output: ignored, not granted.
//  - head on input that already owns an output: ignored (no grant, no state change).
//  i_cand[i]=0 for a head -> never granted (no error); routing guarantees nonzero for legal traffic.
//  Credit 0 blocks both new heads and owner body flits on that output.
//  Reset mid-packet: locks dropped, credits restored; upstream flushes in-flight packets.
// TESTING
//  1 Reset, input 1 head cand=00100 -> o_grant=00001... no: o_grant[1]=1, xbar_valid[2]=1, sel[2]=1,
//    output 2 locked; body flits granted each cycle; tail frees output 2 from the next cycle.
//  2 Inputs 0,3 heads both cand={east} same cycle, rr_ptr=0 -> input 0 wins; after its tail,
//    contention again -> input 3 wins (rr_ptr=1).
//  3 Input 2 cand={north,west}, credit north=1, west=3 -> west chosen; equal credits -> north.
//  4 Lock output 1 by input 4, send DEPTH=4 flits, no returns -> 5th flit stalled (credit 0);
//    one i_credit_return -> granted next cycle; return+forward same cycle keeps credit constant.
//  5 Head&tail single-flit on input 0 to local -> granted, output 0 free next cycle; extra
//    credit_return at credit=4 -> o_err=1, credit stays 4.
//  6 Assert i_reset mid-packet (output 2 locked, credit 1) -> outputs 0 immediately; after release
//    output 2 free, credit=4, o_err=0.

Source files
------------

// File: rtl/odd_even_switch_allocator.sv
`default_nettype none
// ============================================================================
// Module   : odd_even_switch_allocator
// Purpose  : Wormhole switch allocator for one odd-even router. Each input
//            that holds a head flit picks one permitted output: the free,
//            credited output with the most credits, with ties going to the
//            lowest index. Conflicting picks on an output are resolved
//            round-robin. The winning input keeps the output until its tail
//            flit. Downstream credits are tracked per output, and the
//            allocator drives the crossbar select.
// Ports    : i_clk, i_reset (async, active-high)
//            i_valid/i_head/i_tail [N]  flit presence and framing per input
//            i_cand [N*N]               [i*N+o] output o permitted for input i
//            i_credit_return [N]        downstream slot freed, per output
//            o_grant [N]                input i's flit is forwarded (pop it)
//            o_xbar_valid [N]           output o carries a flit
//            o_xbar_sel [N*log2N]       input index driving output o
//            o_err                      sticky protocol-error flag
// Revision : 1.0 - initial release
// ============================================================================
module odd_even_switch_allocator #(
    parameter int N     = 5,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [N-1:0]             i_valid,
    input  logic [N-1:0]             i_head,
    input  logic [N-1:0]             i_tail,
    input  logic [N*N-1:0]           i_cand,
    input  logic [N-1:0]             i_credit_return,
    output logic [N-1:0]             o_grant,
    output logic [N-1:0]             o_xbar_valid,
    output logic [N*$clog2(N)-1:0]   o_xbar_sel,
    output logic                     o_err
);

    localparam int c_SW = $clog2(N);
    localparam int c_CW = $clog2(DEPTH + 1);
    localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

    // ---------------------------------------------------------------- state
    logic [N-1:0]     r_lock;            // per output: owned by an input
    logic [c_SW-1:0]  r_owner  [N];      // per output: owning input
    logic [c_CW-1:0]  r_credit [N];      // per output: free downstream slots
    logic [c_SW-1:0]  r_rr     [N];      // per output: round-robin start
    logic             r_err;

    // ------------------------------------------------------------ combinational
    logic [N-1:0]     w_owns;            // per input: currently owns an output
    logic [c_SW-1:0]  w_owned_out [N];   // per input: which output it owns
    logic [N-1:0]     w_pick_vld;        // per input: head found an eligible output
    logic [c_SW-1:0]  w_pick [N];        // per input: chosen output
    logic [N-1:0]     w_gnt;             // per input
    logic [N-1:0]     w_xv;              // per output
    logic [c_SW-1:0]  w_sel [N];         // per output
    logic [N-1:0]     w_head_win;        // per output: granted flit is a new head
    logic             w_err_evt;

    // Invert the per-output lock table into a per-input view.
    always_comb begin
        w_owns = '0;
        for (int i = 0; i < N; i++) begin
            w_owned_out[i] = '0;
        end
        for (int o = 0; o < N; o++) begin
            for (int i = 0; i < N; i++) begin
                if (r_lock[o] && (r_owner[o] == c_SW'(i))) begin
                    w_owns[i]      = 1'b1;
                    w_owned_out[i] = c_SW'(o);
                end
            end
        end
    end

    // Head selection. A strict compare keeps the lowest index on equal credit.
    // An input that already owns an output has its head ignored.
    always_comb begin
        logic [c_CW-1:0] best;
        best       = '0;
        w_pick_vld = '0;
        for (int i = 0; i < N; i++) begin
            w_pick[i] = '0;
            best      = '0;
            if (i_valid[i] && i_head[i] && !w_owns[i]) begin
                for (int o = 0; o < N; o++) begin
                    if (i_cand[i*N + o] && !r_lock[o] && (r_credit[o] != '0) &&
                        (!w_pick_vld[i] || (r_credit[o] > best))) begin
                        w_pick_vld[i] = 1'b1;
                        w_pick[i]     = c_SW'(o);
                        best          = r_credit[o];
                    end
                end
            end
        end
    end

    // Output arbitration for heads, then exclusive owner traffic. A head can
    // only target a free output and body flits only their locked output, so
    // the two sources never collide on the same output.
    always_comb begin
        logic [c_SW:0] idx;
        idx        = '0;
        w_gnt      = '0;
        w_xv       = '0;
        w_head_win = '0;
        for (int o = 0; o < N; o++) begin
            w_sel[o] = '0;
        end
        for (int o = 0; o < N; o++) begin
            if (!r_lock[o]) begin
                for (int k = 0; k < N; k++) begin
                    idx = {1'b0, r_rr[o]} + (c_SW+1)'(k);
                    if (idx >= (c_SW+1)'(N)) begin
                        idx = idx - (c_SW+1)'(N);
                    end
                    if (!w_xv[o] && w_pick_vld[idx[c_SW-1:0]] &&
                        (w_pick[idx[c_SW-1:0]] == c_SW'(o))) begin
                        w_xv[o]                = 1'b1;
                        w_head_win[o]          = 1'b1;
                        w_sel[o]               = idx[c_SW-1:0];
                        w_gnt[idx[c_SW-1:0]]   = 1'b1;
                    end
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (i_valid[i] && !i_head[i] && w_owns[i] &&
                (r_credit[w_owned_out[i]] != '0)) begin
                w_gnt[i]              = 1'b1;
                w_xv[w_owned_out[i]]  = 1'b1;
                w_sel[w_owned_out[i]] = c_SW'(i);
            end
        end
    end

    // Protocol violations that raise the sticky error flag.
    always_comb begin
        w_err_evt = 1'b0;
        for (int o = 0; o < N; o++) begin
            if (i_credit_return[o] && (r_credit[o] == c_FULL) && !w_xv[o]) begin
                w_err_evt = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (i_valid[i] && !i_head[i] && !w_owns[i]) begin
                w_err_evt = 1'b1;
            end
            if (i_valid[i] && i_head[i] && w_owns[i]) begin
                w_err_evt = 1'b1;
            end
        end
    end

    // Outputs are forced quiet for as long as reset is held.
    always_comb begin
        o_grant      = i_reset ? '0 : w_gnt;
        o_xbar_valid = i_reset ? '0 : w_xv;
        o_xbar_sel   = '0;
        for (int o = 0; o < N; o++) begin
            if (!i_reset && w_xv[o]) begin
                o_xbar_sel[o*c_SW +: c_SW] = w_sel[o];
            end
        end
    end

    assign o_err = r_err;

    // ----------------------------------------------------------- state update
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_lock <= '0;
            r_err  <= 1'b0;
            for (int o = 0; o < N; o++) begin
                r_owner[o]  <= '0;
                r_credit[o] <= c_FULL;
                r_rr[o]     <= '0;
            end
        end else begin
            for (int o = 0; o < N; o++) begin
                // A tail (including a single-flit head&tail) releases the
                // output. Only a multi-flit head takes the lock.
                if (w_xv[o]) begin
                    if (i_tail[w_sel[o]]) begin
                        r_lock[o] <= 1'b0;
                    end else if (w_head_win[o]) begin
                        r_lock[o]  <= 1'b1;
                        r_owner[o] <= w_sel[o];
                    end
                end
                if (w_head_win[o]) begin
                    r_rr[o] <= (w_sel[o] == c_SW'(N-1)) ? '0 : w_sel[o] + 1'b1;
                end
                // A forward and a return in the same cycle cancel. A
                // return while already full is dropped and flagged.
                if (w_xv[o] && !i_credit_return[o]) begin
                    r_credit[o] <= r_credit[o] - 1'b1;
                end else if (!w_xv[o] && i_credit_return[o] && (r_credit[o] != c_FULL)) begin
                    r_credit[o] <= r_credit[o] + 1'b1;
                end
            end
            if (w_err_evt) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_odd_even_switch_allocator.sv
`default_nettype none
// ============================================================================
// Module   : tb_odd_even_switch_allocator
// Purpose  : Self-checking bench for odd_even_switch_allocator. A reference
//            model is compared against the DUT on every falling clock edge.
//            Directed scenarios with literal expectations are followed by
//            randomized packet traffic that respects credits.
// Revision : 1.0 - initial release
// ============================================================================
module tb_odd_even_switch_allocator;

    localparam int N     = 5;
    localparam int DEPTH = 4;
    localparam int SW    = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     valid, head, tail, ret;
    logic [N*N-1:0]   cand;
    logic [N-1:0]     gnt, xv;
    logic [N*SW-1:0]  sel;
    logic             err;

    odd_even_switch_allocator #(.N(N), .DEPTH(DEPTH)) dut (
        .i_clk           (clk),
        .i_reset         (rst),
        .i_valid         (valid),
        .i_head          (head),
        .i_tail          (tail),
        .i_cand          (cand),
        .i_credit_return (ret),
        .o_grant         (gnt),
        .o_xbar_valid    (xv),
        .o_xbar_sel      (sel),
        .o_err           (err)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------- reference model
    // owner = -1 means the output is free.
    int  m_owner [N];
    int  m_credit[N];
    int  m_rr    [N];
    bit  m_err;
    bit  m_last_gnt[N];
    bit  m_last_xv [N];
    bit  e_gnt[N];
    bit  e_xv [N];
    bit  e_win[N];
    int  e_sel[N];
    bit  e_errevt;

    function automatic void model_reset();
        for (int k = 0; k < N; k++) begin
            m_owner[k]    = -1;
            m_credit[k]   = DEPTH;
            m_rr[k]       = 0;
            m_last_gnt[k] = 0;
            m_last_xv[k]  = 0;
        end
        m_err = 0;
    endfunction

    function automatic void model_eval();
        int own [N];
        int pick[N];
        int i;
        for (int k = 0; k < N; k++) begin
            e_gnt[k] = 0; e_xv[k] = 0; e_win[k] = 0; e_sel[k] = 0;
            own[k] = -1; pick[k] = -1;
        end
        e_errevt = 0;
        if (rst) return;
        for (int o = 0; o < N; o++)
            if (m_owner[o] >= 0) own[m_owner[o]] = o;
        // each head picks the free, credited, permitted output with most credit
        for (int a = 0; a < N; a++)
            if (valid[a] && head[a] && own[a] < 0)
                for (int o = 0; o < N; o++)
                    if (cand[a*N+o] && m_owner[o] < 0 && m_credit[o] > 0 &&
                        (pick[a] < 0 || m_credit[o] > m_credit[pick[a]]))
                        pick[a] = o;
        // round-robin among inputs that picked the same free output
        for (int o = 0; o < N; o++)
            if (m_owner[o] < 0)
                for (int k = 0; k < N; k++) begin
                    i = (m_rr[o] + k) % N;
                    if (!e_xv[o] && pick[i] == o) begin
                        e_xv[o] = 1; e_win[o] = 1; e_sel[o] = i; e_gnt[i] = 1;
                    end
                end
        // owner traffic needs only credit
        for (int a = 0; a < N; a++)
            if (valid[a] && !head[a] && own[a] >= 0 && m_credit[own[a]] > 0) begin
                e_gnt[a] = 1; e_xv[own[a]] = 1; e_sel[own[a]] = a;
            end
        for (int o = 0; o < N; o++)
            if (ret[o] && m_credit[o] == DEPTH && !e_xv[o]) e_errevt = 1;
        for (int a = 0; a < N; a++) begin
            if (valid[a] && !head[a] && own[a] < 0)  e_errevt = 1;
            if (valid[a] && head[a] && own[a] >= 0)  e_errevt = 1;
        end
    endfunction

    function automatic void model_apply();
        for (int o = 0; o < N; o++) begin
            if (e_xv[o]) begin
                if (tail[e_sel[o]])  m_owner[o] = -1;
                else if (e_win[o])   m_owner[o] = e_sel[o];
            end
            if (e_win[o]) m_rr[o] = (e_sel[o] + 1) % N;
            m_credit[o] = m_credit[o] - (e_xv[o] ? 1 : 0) + (ret[o] ? 1 : 0);
            if (m_credit[o] > DEPTH) m_credit[o] = DEPTH;
            m_last_xv[o] = e_xv[o];
        end
        for (int a = 0; a < N; a++) m_last_gnt[a] = e_gnt[a];
        if (e_errevt) m_err = 1;
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else begin
                model_eval();
                model_apply();
            end
        end
    end

    // compare process: every falling edge, all outputs against the model
    initial begin : cmp
        logic [N-1:0]    eg, ex;
        logic [N*SW-1:0] es;
        forever begin
            @(negedge clk);
            model_eval();
            eg = '0; ex = '0; es = '0;
            for (int k = 0; k < N; k++) begin
                eg[k] = e_gnt[k];
                ex[k] = e_xv[k];
                if (e_xv[k]) es[k*SW +: SW] = SW'(e_sel[k]);
            end
            chk("model_grant", 32'(gnt), 32'(eg));
            chk("model_xbar_valid", 32'(xv), 32'(ex));
            chk("model_xbar_sel", 32'(sel), 32'(es));
            chk("model_err", 32'(err), 32'(m_err));
        end
    end

    // ------------------------------------------------------------ stimulus
    function automatic int selof(input int o);
        return int'(sel[o*SW +: SW]);
    endfunction

    task automatic drive_clear();
        valid = '0; head = '0; tail = '0; ret = '0; cand = '0;
    endtask

    task automatic nxt();
        @(posedge clk); #1;
        drive_clear();
    endtask

    task automatic hd(input int i, input logic [N-1:0] c, input bit t);
        valid[i] = 1'b1; head[i] = 1'b1; tail[i] = t; cand[i*N +: N] = c;
    endtask

    task automatic bd(input int i, input bit t);
        valid[i] = 1'b1; head[i] = 1'b0; tail[i] = t;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_clear();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    bit          g_act [N];
    int          g_len [N];
    int          g_sent[N];
    logic [N-1:0] g_cand[N];
    int          occ   [N];

    initial begin
        drive_clear();
        do_reset();

        // reset state
        #2;
        chk("reset_grant", 32'(gnt), 0);
        chk("reset_err", 32'(err), 0);

        // wormhole lock on east, release one cycle after tail
        nxt(); hd(1, 5'b00100, 0); #2;
        chk("t1_head_grant", 32'(gnt), 32'b00010);
        chk("t1_head_xv", 32'(xv), 32'b00100);
        chk("t1_head_sel", selof(2), 1);
        nxt(); bd(1, 0); #2;
        chk("t1_body_grant", 32'(gnt), 32'b00010);
        nxt(); bd(1, 1); hd(3, 5'b00100, 1); #2;
        chk("t1_tail_cycle_grant", 32'(gnt), 32'b00010);
        nxt(); hd(3, 5'b00100, 1); #2;
        chk("t1_after_tail_grant", 32'(gnt), 32'b01000);
        chk("t1_after_tail_sel", selof(2), 3);

        // round-robin on east
        do_reset();
        nxt(); hd(0, 5'b00100, 0); hd(3, 5'b00100, 0); #2;
        chk("t2_first_grant", 32'(gnt), 32'b00001);
        nxt(); bd(0, 1); hd(3, 5'b00100, 0); #2;
        chk("t2_locked_grant", 32'(gnt), 32'b00001);
        nxt(); hd(0, 5'b00100, 1); hd(3, 5'b00100, 1); #2;
        chk("t2_rr_grant", 32'(gnt), 32'b01000);
        chk("t2_rr_sel", selof(2), 3);

        // most-credit output selection, tie to lowest index
        do_reset();
        nxt(); hd(0, 5'b00010, 1); hd(1, 5'b10000, 1); #2;
        chk("t3_setup_grant", 32'(gnt), 32'b00011);
        repeat (2) begin
            nxt(); hd(0, 5'b00010, 1); #2;
            chk("t3_drain_north", 32'(gnt), 32'b00001);
        end
        nxt(); hd(2, 5'b10010, 1); #2;
        chk("t3_more_credit_xv", 32'(xv), 32'b10000);
        chk("t3_more_credit_sel", selof(4), 2);
        do_reset();
        nxt(); hd(2, 5'b10010, 1); #2;
        chk("t3_tie_xv", 32'(xv), 32'b00010);

        // credit exhaustion and return
        do_reset();
        nxt(); hd(4, 5'b00010, 0); #2;
        chk("t4_head", 32'(gnt), 32'b10000);
        repeat (3) begin
            nxt(); bd(4, 0); #2;
            chk("t4_body", 32'(gnt), 32'b10000);
        end
        nxt(); bd(4, 0); #2;
        chk("t4_stall", 32'(gnt), 0);
        nxt(); bd(4, 0); ret[1] = 1'b1; #2;
        chk("t4_return_cycle", 32'(gnt), 0);
        nxt(); bd(4, 0); ret[1] = 1'b1; #2;
        chk("t4_after_return", 32'(gnt), 32'b10000);
        nxt(); bd(4, 0); #2;
        chk("t4_credit_kept", 32'(gnt), 32'b10000);
        nxt(); bd(4, 0); #2;
        chk("t4_stall_again", 32'(gnt), 0);
        chk("t4_no_err", 32'(err), 0);

        // single-flit packet and spurious credit return
        do_reset();
        nxt(); hd(0, 5'b00001, 1); #2;
        chk("t5_single_grant", 32'(gnt), 32'b00001);
        chk("t5_single_xv", 32'(xv), 32'b00001);
        nxt(); hd(1, 5'b00001, 1); #2;
        chk("t5_local_free", 32'(gnt), 32'b00010);
        nxt(); ret[3] = 1'b1; #2;
        chk("t5_err_not_yet", 32'(err), 0);
        nxt(); #2;
        chk("t5_err_set", 32'(err), 1);
        repeat (4) begin
            nxt(); hd(0, 5'b01000, 1); #2;
            chk("t5_south_credit", 32'(gnt), 32'b00001);
        end
        nxt(); hd(0, 5'b01000, 1); #2;
        chk("t5_south_held_at_depth", 32'(gnt), 0);

        // orphan body flit, and head on an input that already owns
        do_reset();
        nxt(); bd(2, 0); #2;
        chk("err_orphan_grant", 32'(gnt), 0);
        nxt(); #2;
        chk("err_orphan_flag", 32'(err), 1);
        do_reset();
        nxt(); hd(2, 5'b00100, 0); #2;
        chk("err_dup_first", 32'(gnt), 32'b00100);
        nxt(); hd(2, 5'b00010, 0); #2;
        chk("err_dup_ignored", 32'(gnt), 0);
        nxt(); bd(2, 1); #2;
        chk("err_dup_flag", 32'(err), 1);
        chk("err_dup_still_owns", 32'(gnt), 32'b00100);

        // reset in the middle of a packet
        do_reset();
        nxt(); hd(0, 5'b00100, 0); ret[3] = 1'b1;
        nxt(); bd(0, 0);
        nxt(); bd(0, 0);
        nxt(); bd(0, 0); #2;
        chk("t6_pre_grant", 32'(gnt), 32'b00001);
        chk("t6_pre_err", 32'(err), 1);
        #1 rst = 1'b1;
        #1;
        chk("t6_rst_grant", 32'(gnt), 0);
        chk("t6_rst_xv", 32'(xv), 0);
        chk("t6_rst_sel", 32'(sel), 0);
        @(posedge clk); #1;
        rst = 1'b0; drive_clear(); #2;
        chk("t6_err_cleared", 32'(err), 0);
        nxt(); hd(3, 5'b00100, 0); #2;
        chk("t6_east_free", 32'(gnt), 32'b01000);
        repeat (3) begin
            nxt(); bd(3, 0); #2;
            chk("t6_credit_restored", 32'(gnt), 32'b01000);
        end
        nxt(); bd(3, 0); #2;
        chk("t6_credit_exhausted", 32'(gnt), 0);

        // randomized legal traffic
        do_reset();
        drive_clear();
        for (int k = 0; k < N; k++) begin
            g_act[k] = 0; g_len[k] = 0; g_sent[k] = 0; g_cand[k] = '0; occ[k] = 0;
        end
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (g_act[i] && valid[i] && m_last_gnt[i]) begin
                    g_sent[i]++;
                    if (g_sent[i] == g_len[i]) g_act[i] = 0;
                end
                if (!g_act[i] && $urandom_range(0, 2) == 0) begin
                    g_act[i]  = 1;
                    g_len[i]  = int'($urandom_range(1, 4));
                    g_sent[i] = 0;
                    g_cand[i] = N'($urandom_range(1, 31));
                end
                valid[i] = g_act[i] && (g_sent[i] == 0 || $urandom_range(0, 3) != 0);
                head[i]  = g_act[i] && g_sent[i] == 0;
                tail[i]  = g_act[i] && g_sent[i] == g_len[i] - 1;
                cand[i*N +: N] = g_cand[i];
            end
            for (int o = 0; o < N; o++) begin
                occ[o] += m_last_xv[o] ? 1 : 0;
                ret[o] = 1'b0;
                if (occ[o] > 0 && $urandom_range(0, 2) == 0) begin
                    ret[o] = 1'b1;
                    occ[o]--;
                end
            end
        end

        nxt();
        @(posedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
